// File: rtl/cdc_ps2pl_bank_if.sv
// -----------------------------------------------------------------------------
// cdc_ps2pl_bank_if
// Bundles the PS-side configuration bank and the committed PL-side bank of
// cdc_ps2pl_bank into one interface.
//   i_data        PS words, flattened, word k = [k*DATA_W +: DATA_W] (async)
//   i_update_tog  PS update request, every level change is one request (async)
//   o_data        committed bank, same packing as i_data
//   o_commit      one-cycle pulse in the first cycle new o_data is visible
//   o_busy        high while a request is settling
//   o_commit_cnt  number of commits, wrapping 16-bit counter
// Modports: master = PS register file side, slave = the synchroniser bank.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface cdc_ps2pl_bank_if #(
  parameter int N_CH   = 10,
  parameter int DATA_W = 32
);
  logic [N_CH*DATA_W-1:0] i_data;
  logic                   i_update_tog;
  logic [N_CH*DATA_W-1:0] o_data;
  logic                   o_commit;
  logic                   o_busy;
  logic [15:0]            o_commit_cnt;

  modport master (
    output i_data,
    output i_update_tog,
    input  o_data,
    input  o_commit,
    input  o_busy,
    input  o_commit_cnt
  );

  modport slave (
    input  i_data,
    input  i_update_tog,
    output o_data,
    output o_commit,
    output o_busy,
    output o_commit_cnt
  );
endinterface

// File: rtl/cdc_ps2pl_bank.sv
// -----------------------------------------------------------------------------
// cdc_ps2pl_bank
// Brings N_CH quasi-static PS configuration words into the i_PL_clk domain and
// commits the whole bank atomically. A commit happens only after a level change
// of the PS update toggle, and only once the synchronised data has been stable
// for SETTLE_CYC consecutive cycles. BYPASS = 1 gives the legacy behaviour where
// the outputs follow the synchronised data every cycle.
// Ports:
//   i_PL_clk  PL clock
//   i_rst_n   synchronous active-low reset
//   bus       cdc_ps2pl_bank_if.slave (i_data, i_update_tog in;
//             o_data, o_commit, o_busy, o_commit_cnt out)
// Parameters: N_CH, DATA_W, SYNC_STAGES (2..4), SETTLE_CYC (>= 1), BYPASS.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module cdc_ps2pl_bank #(
  parameter int N_CH        = 10,
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 4,
  parameter int BYPASS      = 0
) (
  input  logic             i_PL_clk,
  input  logic             i_rst_n,
  cdc_ps2pl_bank_if.slave  bus
);

  localparam int BANK_W = N_CH * DATA_W;
  localparam int CNT_W  = $clog2(SETTLE_CYC + 1);
  localparam int ARM_W  = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
  // Edge detection opens SYNC_STAGES+1 cycles after reset release, i.e. once a
  // toggle level present during reset has fully propagated into tog_dly_q.
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  // Synchroniser chains
  logic [BANK_W-1:0]      data_pipe_q [SYNC_STAGES];
  logic [BANK_W-1:0]      data_pipe_d [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] tog_pipe_q, tog_pipe_d;
  logic [BANK_W-1:0]      data_dly_q, data_dly_d;
  logic                   tog_dly_q, tog_dly_d;

  // Control and output state
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ARM_W-1:0]       arm_cnt_q, arm_cnt_d;
  logic [BANK_W-1:0]      o_data_q, o_data_d;
  logic                   commit_q, commit_d;
  logic                   busy_q, busy_d;
  logic [15:0]            commit_cnt_q, commit_cnt_d;

  logic [BANK_W-1:0]      data_sync;
  logic                   tog_sync;
  logic                   armed;
  logic                   tog_edge;

  assign data_sync = data_pipe_q[SYNC_STAGES-1];
  assign tog_sync  = tog_pipe_q[SYNC_STAGES-1];
  assign armed     = (arm_cnt_q == ARM_DONE);
  assign tog_edge  = armed & (tog_sync ^ tog_dly_q);

  // Next values of the synchroniser chains and their one-cycle delayed copies
  always_comb begin
    data_pipe_d[0] = bus.i_data;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      data_pipe_d[i] = data_pipe_q[i-1];
    end
    tog_pipe_d = {tog_pipe_q[SYNC_STAGES-2:0], bus.i_update_tog};
    data_dly_d = data_sync;
    tog_dly_d  = tog_sync;
  end

  // Arming counter, settle FSM and commit of the output bank
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    o_data_d     = o_data_q;
    commit_d     = 1'b0;
    commit_cnt_d = commit_cnt_q;

    if (armed) begin
      arm_cnt_d = arm_cnt_q;
    end else begin
      arm_cnt_d = arm_cnt_q + 3'd1;
    end

    if (BYPASS != 0) begin
      state_d      = IDLE;
      cnt_d        = '0;
      o_data_d     = data_sync;
      commit_cnt_d = 16'h0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (tog_edge) begin
            state_d = SETTLE;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
        SETTLE: begin
          // A new request and data movement both restart the window; a request
          // arriving together with the commit decision therefore wins.
          if (tog_edge) begin
            cnt_d = '0;
          end else if (data_sync != data_dly_q) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d      = IDLE;
            cnt_d        = '0;
            o_data_d     = data_sync;
            commit_d     = 1'b1;
            commit_cnt_d = commit_cnt_q + 16'd1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Registered from the next state so o_busy lines up exactly with state_q.
    busy_d = (state_d == SETTLE);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge i_PL_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        data_pipe_q[i] <= '0;
      end
      tog_pipe_q   <= '0;
      data_dly_q   <= '0;
      tog_dly_q    <= 1'b0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      arm_cnt_q    <= '0;
      o_data_q     <= '0;
      commit_q     <= 1'b0;
      busy_q       <= 1'b0;
      commit_cnt_q <= 16'h0000;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        data_pipe_q[i] <= data_pipe_d[i];
      end
      tog_pipe_q   <= tog_pipe_d;
      data_dly_q   <= data_dly_d;
      tog_dly_q    <= tog_dly_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      arm_cnt_q    <= arm_cnt_d;
      o_data_q     <= o_data_d;
      commit_q     <= commit_d;
      busy_q       <= busy_d;
      commit_cnt_q <= commit_cnt_d;
    end
  end

  assign bus.o_data       = o_data_q;
  assign bus.o_commit     = commit_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_commit_cnt = commit_cnt_q;

endmodule
